// File: rtl/spm_regfile_bus1_pkg.sv
// Shared constants for the SPM register file / bus1 source selector.
// Holds the default build sizes, the fixed bus1 select codes and the
// source-kind enum used by the top level.
package spm_regfile_bus1_pkg;

  // Default build: 8-bit datapath, four general registers, 3-bit select.
  localparam int unsigned SPM_WIDTH    = 8;
  localparam int unsigned SPM_NUM_REGS = 4;
  localparam int unsigned SPM_SEL_W    = 3;

  // bus1 select codes for the default build; PC follows the last register.
  localparam logic [SPM_SEL_W-1:0] SEL_MUX1_R0 = SPM_SEL_W'(0);
  localparam logic [SPM_SEL_W-1:0] SEL_MUX1_R1 = SPM_SEL_W'(1);
  localparam logic [SPM_SEL_W-1:0] SEL_MUX1_R2 = SPM_SEL_W'(2);
  localparam logic [SPM_SEL_W-1:0] SEL_MUX1_R3 = SPM_SEL_W'(3);
  localparam logic [SPM_SEL_W-1:0] SEL_MUX1_PC = SPM_SEL_W'(SPM_NUM_REGS);

  // Kind of source a select code resolves to.
  typedef enum logic {
    SRC_REG = 1'b0,
    SRC_PC  = 1'b1
  } bus1_src_e;

endpackage

// File: rtl/spm_regfile_bus1_sel_mux.sv
// spm_sel_mux: combinational bus1 source selector.
// Ports:
//   regs_flat_i  flattened register array, R0 in the LSBs
//   pc_i         program counter, selected for every non-register code
//   sel_i        select code
//   data_o       selected word
module spm_sel_mux #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned SEL_W    = 3
) (
  input  logic [WIDTH*NUM_REGS-1:0] regs_flat_i,
  input  logic [WIDTH-1:0]          pc_i,
  input  logic [SEL_W-1:0]          sel_i,
  output logic [WIDTH-1:0]          data_o
);

  // PC is the default so unused codes always drive a defined value.
  always_comb begin
    data_o = pc_i;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (sel_i == SEL_W'(i)) begin
        data_o = regs_flat_i[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/spm_regfile_bus1.sv
// spm_regfile_bus1: general-purpose register file with the bus1 source
// selector, a bus2 write port, optional write-to-read bypass and an
// optional registered bus1 stage.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   bus2         write data
//   wr_en        write strobe
//   wr_addr      destination register; indices >= NUM_REGS are dropped
//   pc           program counter, a bus1 source
//   sel_mux1     bus1 source select
//   rd_en        capture strobe for the registered bus1 (REG_OUT=1 only)
//   bus1         selected source
//   bus1_vld     bus1 valid; constant 1 when REG_OUT=0
//   regs_flat    debug view of all registers, R0 in the LSBs
module spm_regfile_bus1
  import spm_regfile_bus1_pkg::*;
#(
  parameter int unsigned WIDTH    = SPM_WIDTH,
  parameter int unsigned NUM_REGS = SPM_NUM_REGS,
  parameter int unsigned SEL_W    = SPM_SEL_W,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned REG_OUT  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          bus2,
  input  logic                      wr_en,
  input  logic [SEL_W-1:0]          wr_addr,
  input  logic [WIDTH-1:0]          pc,
  input  logic [SEL_W-1:0]          sel_mux1,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          bus1,
  output logic                      bus1_vld,
  output logic [WIDTH*NUM_REGS-1:0] regs_flat
);

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic             wr_hit;
  logic             byp_hit;
  bus1_src_e        sel_src;
  logic [WIDTH-1:0] arr_sel;
  logic [WIDTH-1:0] sel_val;

  // A write only takes effect when it addresses an implemented register.
  assign wr_hit = wr_en && (32'(wr_addr) < NUM_REGS);

  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (wr_hit && (wr_addr == SEL_W'(i))) begin
        regs_d[i] = bus2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
    end
  end

  spm_sel_mux #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_sel_mux (
    .regs_flat_i (regs_flat),
    .pc_i        (pc),
    .sel_i       (sel_mux1),
    .data_o      (arr_sel)
  );

  assign sel_src = (32'(sel_mux1) < NUM_REGS) ? SRC_REG : SRC_PC;

  // Forward bus2 when this cycle's write targets the selected register;
  // PC selections are never forwarded.
  assign byp_hit = (BYPASS != 0) && wr_hit && (sel_src == SRC_REG) &&
                   (wr_addr == sel_mux1);
  assign sel_val = byp_hit ? bus2 : arr_sel;

  if (REG_OUT != 0) begin : g_reg_out
    logic [WIDTH-1:0] bus1_q;
    logic [WIDTH-1:0] bus1_d;
    logic             vld_q;
    logic             vld_d;

    // Capture on rd_en; valid is a one-cycle pulse per capture.
    always_comb begin
      bus1_d = bus1_q;
      vld_d  = 1'b0;
      if (rd_en) begin
        bus1_d = sel_val;
        vld_d  = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        bus1_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        bus1_q <= bus1_d;
        vld_q  <= vld_d;
      end
    end

    assign bus1     = bus1_q;
    assign bus1_vld = vld_q;
  end else begin : g_comb_out
    logic unused_rd_en;

    assign unused_rd_en = rd_en;
    assign bus1         = sel_val;
    assign bus1_vld     = 1'b1;
  end

endmodule

// File: tb/tb_spm_regfile_bus1.sv
// Bench for spm_regfile_bus1: four instances covering BYPASS x REG_OUT,
// driven in lockstep and checked against an array-based reference model.
module tb_spm_regfile_bus1;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;
  localparam int unsigned S = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] bus2;
  logic [W-1:0] pc;
  logic [S-1:0] wr_addr;
  logic [S-1:0] sel_mux1;

  logic [W-1:0]   bus1_b1r0, bus1_b0r0, bus1_b1r1, bus1_b0r1;
  logic           vld_b1r0, vld_b0r0, vld_b1r1, vld_b0r1;
  logic [W*N-1:0] flat_b1r0, flat_b0r0, flat_b1r1, flat_b0r1;

  always #5 clk = ~clk;

  spm_regfile_bus1 #(.WIDTH(W), .NUM_REGS(N), .SEL_W(S), .BYPASS(1), .REG_OUT(0)) u_b1r0 (
    .clk(clk), .rst(rst), .bus2(bus2), .wr_en(wr_en), .wr_addr(wr_addr), .pc(pc),
    .sel_mux1(sel_mux1), .rd_en(rd_en), .bus1(bus1_b1r0), .bus1_vld(vld_b1r0),
    .regs_flat(flat_b1r0));
  spm_regfile_bus1 #(.WIDTH(W), .NUM_REGS(N), .SEL_W(S), .BYPASS(0), .REG_OUT(0)) u_b0r0 (
    .clk(clk), .rst(rst), .bus2(bus2), .wr_en(wr_en), .wr_addr(wr_addr), .pc(pc),
    .sel_mux1(sel_mux1), .rd_en(rd_en), .bus1(bus1_b0r0), .bus1_vld(vld_b0r0),
    .regs_flat(flat_b0r0));
  spm_regfile_bus1 #(.WIDTH(W), .NUM_REGS(N), .SEL_W(S), .BYPASS(1), .REG_OUT(1)) u_b1r1 (
    .clk(clk), .rst(rst), .bus2(bus2), .wr_en(wr_en), .wr_addr(wr_addr), .pc(pc),
    .sel_mux1(sel_mux1), .rd_en(rd_en), .bus1(bus1_b1r1), .bus1_vld(vld_b1r1),
    .regs_flat(flat_b1r1));
  spm_regfile_bus1 #(.WIDTH(W), .NUM_REGS(N), .SEL_W(S), .BYPASS(0), .REG_OUT(1)) u_b0r1 (
    .clk(clk), .rst(rst), .bus2(bus2), .wr_en(wr_en), .wr_addr(wr_addr), .pc(pc),
    .sel_mux1(sel_mux1), .rd_en(rd_en), .bus1(bus1_b0r1), .bus1_vld(vld_b0r1),
    .regs_flat(flat_b0r1));

  // Reference state: register contents and the two captured bus1 values.
  logic [W-1:0] mem [N];
  logic [W-1:0] exp_q_b1;
  logic [W-1:0] exp_q_b0;
  logic         exp_vld;

  int unsigned n_vec;
  int unsigned n_miscmp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Value bus1 should present for the current inputs.
  function automatic logic [W-1:0] model_sel(input bit byp);
    if (int'(sel_mux1) < int'(N)) begin
      if (byp && wr_en && (wr_addr == sel_mux1)) return bus2;
      return mem[int'(sel_mux1)];
    end
    return pc;
  endfunction

  function automatic logic [W*N-1:0] model_flat();
    logic [W*N-1:0] f;
    for (int i = 0; i < int'(N); i++) f[i*W +: W] = mem[i];
    return f;
  endfunction

  // Apply inputs in the low phase and check the combinational instances.
  task automatic drive(input bit r, input bit we, input logic [S-1:0] wa, input logic [W-1:0] d,
                       input logic [W-1:0] p, input logic [S-1:0] s, input bit rd);
    @(negedge clk);
    rst = r; wr_en = we; wr_addr = wa; bus2 = d; pc = p; sel_mux1 = s; rd_en = rd;
    #1;
    check("comb_byp_bus1", 32'(bus1_b1r0), 32'(model_sel(1'b1)));
    check("comb_nobyp_bus1", 32'(bus1_b0r0), 32'(model_sel(1'b0)));
    check("comb_byp_vld", 32'(vld_b1r0), 32'd1);
    check("comb_nobyp_vld", 32'(vld_b0r0), 32'd1);
  endtask

  // Advance the model across one edge, then check state after the edge.
  task automatic tick();
    logic [W-1:0] e1;
    logic [W-1:0] e0;
    e1 = model_sel(1'b1);
    e0 = model_sel(1'b0);
    if (rst) begin
      for (int i = 0; i < int'(N); i++) mem[i] = '0;
      exp_q_b1 = '0;
      exp_q_b0 = '0;
      exp_vld  = 1'b0;
    end else begin
      if (rd_en) begin
        exp_q_b1 = e1;
        exp_q_b0 = e0;
      end
      exp_vld = rd_en;
      if (wr_en && int'(wr_addr) < int'(N)) mem[int'(wr_addr)] = bus2;
    end
    @(posedge clk);
    #1;
    check("flat_b1r0", flat_b1r0, model_flat());
    check("flat_b0r0", flat_b0r0, model_flat());
    check("flat_b1r1", flat_b1r1, model_flat());
    check("flat_b0r1", flat_b0r1, model_flat());
    check("reg_byp_bus1", 32'(bus1_b1r1), 32'(exp_q_b1));
    check("reg_nobyp_bus1", 32'(bus1_b0r1), 32'(exp_q_b0));
    check("reg_byp_vld", 32'(vld_b1r1), 32'(exp_vld));
    check("reg_nobyp_vld", 32'(vld_b0r1), 32'(exp_vld));
  endtask

  task automatic wr(input logic [S-1:0] a, input logic [W-1:0] d);
    drive(1'b0, 1'b1, a, d, 8'h00, 3'd0, 1'b0);
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_miscmp = 0;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; bus2 = '0; pc = '0;
    wr_addr = '0; sel_mux1 = '0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < int'(N); i++) mem[i] = '0;
    exp_q_b1 = '0; exp_q_b0 = '0; exp_vld = 1'b0;
    #1;

    // Load R0..R3, capture R0, then reset with a write and capture pending.
    wr(3'd0, 8'h11);
    wr(3'd1, 8'h22);
    wr(3'd2, 8'h33);
    drive(1'b0, 1'b1, 3'd3, 8'h44, 8'h00, 3'd0, 1'b1);
    tick();
    check("pre_rst_flat", flat_b1r1, 32'h4433_2211);
    check("pre_rst_bus1", 32'(bus1_b1r1), 32'h11);
    drive(1'b1, 1'b1, 3'd0, 8'h55, 8'h00, 3'd0, 1'b1);
    tick();
    check("rst_flat", flat_b1r1, 32'h0);
    check("rst_bus1", 32'(bus1_b1r1), 32'h0);
    check("rst_vld", 32'(vld_b1r1), 32'h0);

    // All sources.
    wr(3'd2, 8'hA5);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h3C, 3'd2, 1'b0);
    check("sel_r2", 32'(bus1_b1r0), 32'hA5);
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h3C, 3'd4, 1'b0);
    check("sel_pc", 32'(bus1_b1r0), 32'h3C);
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h3C, 3'd7, 1'b0);
    check("sel_dflt", 32'(bus1_b1r0), 32'h3C);
    tick();

    // Out-of-range write is dropped.
    drive(1'b0, 1'b1, 3'd5, 8'hFF, 8'h3C, 3'd7, 1'b0);
    tick();
    check("oob_flat", flat_b1r0, 32'h00A5_0000);

    // Same-cycle write and read of R1.
    wr(3'd1, 8'h10);
    drive(1'b0, 1'b1, 3'd1, 8'h99, 8'h00, 3'd1, 1'b1);
    check("byp1_comb", 32'(bus1_b1r0), 32'h99);
    check("byp0_comb", 32'(bus1_b0r0), 32'h10);
    tick();
    check("byp1_cap", 32'(bus1_b1r1), 32'h99);
    check("byp0_cap", 32'(bus1_b0r1), 32'h10);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 3'd1, 1'b0);
    check("byp0_next", 32'(bus1_b0r0), 32'h99);
    tick();
    check("byp_hold_vld", 32'(vld_b1r1), 32'h0);

    // Registered capture pulse and hold.
    wr(3'd3, 8'h7E);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 3'd3, 1'b1);
    tick();
    check("cap_r3", 32'(bus1_b1r1), 32'h7E);
    check("cap_r3_vld", 32'(vld_b1r1), 32'h1);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 3'd3, 1'b0);
    tick();
    check("hold_r3", 32'(bus1_b1r1), 32'h7E);
    check("hold_r3_vld", 32'(vld_b1r1), 32'h0);

    // Random traffic; back-to-back rd_en and collisions occur naturally.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)),
            8'($urandom),
            8'($urandom),
            3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/spm_regfile_bus1.md
Name: spm_regfile_bus1

Overview:
- Parametrised successor to the SPM bus1 source selector.
- Combines the general-purpose register file (R0..R(N-1)) with the bus1 read selector, which picks a register or PC.
- Adds a synchronous write port from bus2, optional write-to-read bypass, and an optional registered bus1 stage with a valid strobe.
- Sits between the control unit (sel_mux1, load/read strobes) and the ALU/memory datapath.

Parameters:
- WIDTH, 8, datapath width of registers, pc, bus2 and bus1.
- NUM_REGS, 4, number of general registers; legal range 2..15.
- SEL_W, 3, width of sel_mux1 and wr_addr; must satisfy 2**SEL_W > NUM_REGS.
- BYPASS, 1, 1 = a same-cycle write to the selected register is forwarded to bus1; 0 = bus1 shows the pre-write value.
- REG_OUT, 0, 0 = bus1 is combinational from the register array; 1 = bus1 is registered and qualified by bus1_vld.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- bus2  in  WIDTH  write data.
- wr_en  in  1  write strobe.
- wr_addr  in  SEL_W  destination register index.
- pc  in  WIDTH  program counter value, a bus1 source.
- sel_mux1  in  SEL_W  bus1 source select.
- rd_en  in  1  capture strobe for the registered output; ignored when REG_OUT=0.
- bus1  out  WIDTH  selected source.
- bus1_vld  out  1  bus1 valid; tied to 1 when REG_OUT=0.
- regs_flat  out  WIDTH*NUM_REGS  debug view of all registers, R0 in the LSBs.

Behaviour:
- Reset, synchronous, active-high:
  - rst=1 at a clk edge clears every register and the bus1 output register to 0.
  - bus1_vld clears to 0.
  - rst dominates wr_en and rd_en in the same cycle.
  - Reset asserted mid-sequence discards any write or capture presented in that cycle.
- Write:
  - On a clk edge with wr_en=1 and wr_addr<NUM_REGS: R[wr_addr] <= bus2.
  - wr_addr>=NUM_REGS: the write is silently dropped and no register changes.
  - Write latency is one cycle; the new value is visible in regs_flat after the edge.
- Select decode:
  - sel_mux1 in 0..NUM_REGS-1 selects R[sel_mux1].
  - sel_mux1 == NUM_REGS selects pc.
  - Any other code selects pc (default).
- Bypass (BYPASS=1):
  - If wr_en=1, wr_addr<NUM_REGS and wr_addr==sel_mux1, the selected value is bus2 instead of R[sel_mux1].
  - pc-select codes are never bypassed.
  - BYPASS=0: the selected value is always the array contents.
- REG_OUT=0:
  - bus1 is the selected value, combinational, zero latency.
  - bus1_vld=1 permanently, including during reset.
- REG_OUT=1:
  - On a clk edge with rd_en=1: bus1 <= selected value (bypass applies per BYPASS) and bus1_vld <= 1.
  - rd_en=0: bus1 holds its last value; bus1_vld <= 0, i.e. a one-cycle pulse per capture.
  - Back-to-back rd_en gives one capture per cycle with bus1_vld held at 1.
  - Simultaneous write and capture of the same register: the captured value is bus2 if BYPASS=1, otherwise the old register value.
- No X propagation: every select code and every address drives a defined value.

Decomposition:
- Shared header spm_head.v holds:
  - SEL_MUX1_R0..R3 codes.
  - SEL_MUX1_PC, redefined as NUM_REGS for the default build (4).
  - Default WIDTH/NUM_REGS macros.
- Sub-module spm_sel_mux:
  - Parametrised (WIDTH, NUM_REGS, SEL_W), combinational.
  - Takes the flattened register array, pc and sel, and returns the selected word with pc as default.
  - Instantiated once; the bypass comparison and output register stay in the top.

Test Plan:
- Reset: load R0..R3 = 8'h11/22/33/44, assert rst one cycle → regs_flat=32'h0, bus1 (REG_OUT=1)=8'h00, bus1_vld=0.
- Write/read all sources: write 8'hA5 to R2, sel_mux1=2 → bus1=8'hA5. sel=4 with pc=8'h3C → bus1=8'h3C. sel=7 → bus1=8'h3C.
- Out-of-range write: wr_addr=5, bus2=8'hFF → all registers unchanged.
- Bypass: R1=8'h10, same cycle wr_en=1, wr_addr=1, bus2=8'h99, sel=1:
  - BYPASS=1 → bus1=8'h99.
  - BYPASS=0 → bus1=8'h10 that cycle, 8'h99 the next.
- Registered output (REG_OUT=1):
  - rd_en pulse with sel=3, R3=8'h7E → bus1=8'h7E and bus1_vld=1 one cycle after the edge.
  - Next cycle rd_en=0 → bus1 holds 8'h7E, bus1_vld=0.
- Reset mid-operation: wr_en=1 to R0 with bus2=8'h55 and rst=1 in the same cycle → R0=8'h00 afterwards, no capture, bus1_vld=0.
